// File: rtl/row_xor_lookup_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : row_xor_lookup_decode_if
// Brief    : Request/result bundle for the XOR hash-row lookup decoder.
// Revision : 1.0
// ============================================================================
interface row_xor_lookup_decode_if #(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int KEY_WIDTH   = 32
);
  localparam int VALUE_WIDTH = DATA_WIDTH - 1 - KEY_WIDTH;

  logic [1:0]                            in_opt;
  logic [KEY_WIDTH-1:0]                  in_key;
  logic [INDEX_WIDTH-1:0]                in_index;
  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  in_rows;
  logic                                  out_ready;
  logic                                  out_valid;
  logic [1:0]                            out_opt;
  logic [KEY_WIDTH-1:0]                  out_key;
  logic [INDEX_WIDTH-1:0]                out_index;
  logic                                  out_hit;
  logic [NUM_MUL-1:0]                    out_hit_slot;
  logic [VALUE_WIDTH-1:0]                out_value;
  logic [NUM_MUL-1:0]                    out_free_slot;
  logic                                  out_full;
  logic                                  overflow;
  logic [31:0]                           hit_count;
  logic [31:0]                           miss_count;

  modport master (
    output in_opt, in_key, in_index, in_rows, out_ready,
    input  out_valid, out_opt, out_key, out_index, out_hit, out_hit_slot,
           out_value, out_free_slot, out_full, overflow, hit_count, miss_count
  );

  modport slave (
    input  in_opt, in_key, in_index, in_rows, out_ready,
    output out_valid, out_opt, out_key, out_index, out_hit, out_hit_slot,
           out_value, out_free_slot, out_full, overflow, hit_count, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/row_xor_lookup_decode.sv
`default_nettype none
// ============================================================================
// Module   : row_xor_lookup_decode
// Brief    : XOR-reduces banked row copies, matches the key, queues results.
// Revision : 1.0
// ============================================================================
module row_xor_lookup_decode #(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int KEY_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  row_xor_lookup_decode_if.slave bus
);
  localparam int VALUE_WIDTH = DATA_WIDTH - 1 - KEY_WIDTH;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int RES_W       = 2 + KEY_WIDTH + INDEX_WIDTH + 1 + NUM_MUL + VALUE_WIDTH + NUM_MUL + 1;

  // Stage S1: recovered entries
  logic [DATA_WIDTH-1:0]  entry_d [NUM_MUL];
  logic [DATA_WIDTH-1:0]  s1_entry_q [NUM_MUL];
  logic                   s1_valid_q;
  logic [1:0]             s1_opt_q;
  logic [KEY_WIDTH-1:0]   s1_key_q;
  logic [INDEX_WIDTH-1:0] s1_index_q;

  always_comb begin
    for (int m = 0; m < NUM_MUL; m++) begin
      entry_d[m] = '0;
      for (int i = 0; i < NUM_WR; i++) begin
        entry_d[m] = entry_d[m] ^ bus.in_rows[DATA_WIDTH*(NUM_MUL*i+m) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_opt_q   <= '0;
      s1_key_q   <= '0;
      s1_index_q <= '0;
      for (int m = 0; m < NUM_MUL; m++) s1_entry_q[m] <= '0;
    end else begin
      s1_valid_q <= (bus.in_opt != 2'd0);
      s1_opt_q   <= bus.in_opt;
      s1_key_q   <= bus.in_key;
      s1_index_q <= bus.in_index;
      for (int m = 0; m < NUM_MUL; m++) s1_entry_q[m] <= entry_d[m];
    end
  end

  // Stage S2: match and free-slot search; descending scan leaves the lowest slot
  logic [NUM_MUL-1:0]     hit_slot_d;
  logic [NUM_MUL-1:0]     free_slot_d;
  logic [VALUE_WIDTH-1:0] value_d;
  logic                   full_d;
  logic                   s2_valid_q;
  logic [RES_W-1:0]       s2_res_q;

  always_comb begin
    hit_slot_d  = '0;
    free_slot_d = '0;
    value_d     = '0;
    full_d      = 1'b1;
    for (int m = NUM_MUL - 1; m >= 0; m--) begin
      if (s1_entry_q[m][DATA_WIDTH-1] && (s1_entry_q[m][DATA_WIDTH-2 -: KEY_WIDTH] == s1_key_q)) begin
        hit_slot_d = {{(NUM_MUL-1){1'b0}}, 1'b1} << m;
        value_d    = s1_entry_q[m][VALUE_WIDTH-1:0];
      end
      if (!s1_entry_q[m][DATA_WIDTH-1]) begin
        free_slot_d = {{(NUM_MUL-1){1'b0}}, 1'b1} << m;
        full_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_res_q   <= {s1_opt_q, s1_key_q, s1_index_q, |hit_slot_d, hit_slot_d,
                     value_d, free_slot_d, full_d};
    end
  end

  // Output FIFO; a push into a full FIFO survives only if a pop frees a slot
  logic [RES_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_valid;
  logic             pop;
  logic             push_ok;
  logic [RES_W-1:0] head;

  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.out_ready;
  assign push_ok    = s2_valid_q && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= s2_res_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  assign head          = fifo_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_valid = fifo_valid;
  assign {bus.out_opt, bus.out_key, bus.out_index, bus.out_hit, bus.out_hit_slot,
          bus.out_value, bus.out_free_slot, bus.out_full} = head;

  // Statistics count every S2 search, including ones the FIFO drops
  logic        s2_search;
  logic        s2_hit;
  logic        overflow_q;
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  assign s2_search = s2_valid_q && (s2_res_q[RES_W-1 -: 2] == 2'd1);
  assign s2_hit    = s2_res_q[2*NUM_MUL + VALUE_WIDTH + 1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (s2_valid_q && !push_ok) overflow_q <= 1'b1;
      if (s2_search && s2_hit && (hit_count_q != '1))    hit_count_q  <= hit_count_q + 32'd1;
      if (s2_search && !s2_hit && (miss_count_q != '1))  miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign bus.overflow   = overflow_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
endmodule
`default_nettype wire

// File: doc/row_xor_lookup_decode.md
# row_xor_lookup_decode

Read-side decoder for an XOR multi-write hash row. It consumes the bank-replicated read word produced by the row read pipeline, XOR-reduces the NUM_WR bank copies of each of the NUM_MUL slots to recover the true stored entries, and compares them against the request key. It then emits one lookup result per request (hit, slot, value, first free slot) through a small output FIFO with a valid/ready handshake, and keeps search hit/miss statistics. It sits directly after the row read pipeline and feeds the insert/delete control and the host response path.

## Interface
- NUM_MUL, 4, slots per row (XOR-banked entries per index)
- NUM_WR, 8, write-port banks whose copies are XOR-combined
- INDEX_WIDTH, 12, row index width (pass-through)
- DATA_WIDTH, 64, stored entry width
- KEY_WIDTH, 32, key width; VALUE_WIDTH = DATA_WIDTH-1-KEY_WIDTH (31 at defaults)
- FIFO_DEPTH, 4, output FIFO depth, power of two, ≥2

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_opt  in  2  request opcode: 0 none, 1 search, 2 insert, 3 delete
- in_key  in  KEY_WIDTH  request key, aligned with in_rows
- in_index  in  INDEX_WIDTH  row index, carried to output
- in_rows  in  NUM_MUL*NUM_WR*DATA_WIDTH  bank i slot m at [DATA_WIDTH*(NUM_MUL*i+m) +: DATA_WIDTH]
- out_ready  in  1  consumer accepts head result
- out_valid  out  1  FIFO non-empty
- out_opt  out  2  opcode of head result
- out_key  out  KEY_WIDTH  key of head result
- out_index  out  INDEX_WIDTH  index of head result
- out_hit  out  1  a valid slot matches key
- out_hit_slot  out  NUM_MUL  one-hot matching slot, 0 if no hit
- out_value  out  VALUE_WIDTH  value of hit slot, 0 if no hit
- out_free_slot  out  NUM_MUL  one-hot lowest-numbered slot with valid bit 0, 0 if none
- out_full  out  1  all NUM_MUL slots valid
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- hit_count  out  32  saturating count of search hits
- miss_count  out  32  saturating count of search misses

## Operation
- Decode: entry[m] = XOR over i=0..NUM_WR-1 of bank i slot m. Entry fields: bit DATA_WIDTH-1 = valid, [DATA_WIDTH-2 -: KEY_WIDTH] = key, [VALUE_WIDTH-1:0] = value.
- Stage S1 (register): the decoded entries, opcode, key and index. The valid bit is set when in_opt != 0; in_opt = 0 is a bubble and never reaches the FIFO.
- Stage S2 (register): per slot, match[m] = entry valid && entry key == request key. Hit = |match. If multiple slots match, the lowest slot wins (one-hot out_hit_slot). Free slot = lowest m with the valid bit clear. out_full = all valid bits set.
- The FIFO pushes the S2 result whenever S2 is valid.
- Push when full: the result is dropped and overflow is set, unless a pop happens in the same cycle, in which case the push is accepted.
- Pop when out_valid && out_ready.
- Simultaneous push and pop on an empty FIFO: only the push occurs; a result never bypasses the FIFO.
- Pointers wrap modulo FIFO_DEPTH. A separate count, 0..FIFO_DEPTH, distinguishes full from empty.
- Counters update on the S2→FIFO cycle, only for opcode 1: hit_count++ on hit, miss_count++ otherwise. Each saturates at 2^32-1. Dropped results are still counted.
- overflow clears only on reset.

## Timing
- Request sampled at edge t. S1 valid after t, S2 valid after t+1, FIFO write at t+2. out_valid is high after t+2 when the FIFO was empty, giving 2 cycles of latency.
- Throughput is one request per cycle with no stall; upstream cannot be back-pressured.
- The head outputs are stable while out_valid && !out_ready.
- Reset, asynchronous at any time:
  - S1 and S2 valid = 0; FIFO empty.
  - out_valid = 0, out_hit = 0, out_hit_slot = 0, out_free_slot = 0, out_full = 0, out_value = 0, out_opt = 0, out_key = 0, out_index = 0.
  - overflow = 0, hit_count = 0, miss_count = 0.
  - In-flight requests are discarded.

## Test plan
- Single search, defaults: bank 0 slot 2 = {1, key 0xDEADBEEF, value 0x1234}, bank 3 slot 2 = 0x5A5A5A5A5A5A5A5A, bank 5 slot 2 = 0x5A5A5A5A5A5A5A5A, all else 0; in_opt = 1, key 0xDEADBEEF, index 0x7 → 2 cycles later out_valid = 1, out_hit = 1, out_hit_slot = 4'b0100, out_value = 0x1234, out_free_slot = 4'b0001, out_index = 0x7, hit_count = 1.
- Miss and full: all 4 slots valid with keys 1..4; search key 9 → out_hit = 0, out_hit_slot = 0, out_value = 0, out_full = 1, out_free_slot = 0, miss_count = 1.
- Duplicate match: slots 1 and 3 both valid with key 0xAA; search 0xAA → out_hit_slot = 4'b0010 and slot 1's value.
- Back-pressure: out_ready = 0, send 6 back-to-back inserts with FIFO_DEPTH = 4 → 4 results retained in order, overflow = 1; then out_ready = 1 → exactly 4 pops, out_valid = 0 after the 4th pop. In a second run with FIFO full and out_ready = 1 for the push cycle, no drop occurs and overflow stays 0.
- Bubbles and opcodes: alternate in_opt 0/2/0/3 → only 2 results, opcodes 2 then 3; hit_count and miss_count unchanged.
- Reset mid-stream: assert reset asynchronously with 2 requests in flight and 3 queued → all outputs go to their reset values immediately; after release no stale result appears.
